sys_time_monitor: RTL and testbench
===================================

Name: sys_time_monitor

Overview:
- Consumer-side checker for the free-running 64-bit system time counter and its clock-lock flag, as driven by the clock subsystem.
- Verifies that SYS_TIME advances by exactly +1 per CLK cycle while locked, and reports jumps, stalls and lock loss.
- Emits a periodic TICK aligned to SYS_TIME boundaries for downstream timing logic.
- Sits between the clock/sys-time source and the control/status register block.

Parameters:
- TICK_LOG2, 9, TICK asserted when SYS_TIME[TICK_LOG2-1:0] == 0 (period 2^TICK_LOG2 cycles); legal range 1..32.
- ACQ_COUNT, 4, consecutive good increments required in ACQUIRE before entering TRACK; legal range 1..255.
- ERR_WIDTH, 16, width of the saturating error counter.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- LOCKED  input  1  clock-lock flag from the clock subsystem.
- SYS_TIME  input  64  system time; nominally +1 per CLK while LOCKED.
- CLR_ERR  input  1  single-cycle request: clears ERR_CNT and LOCK_LOST.
- STATE  output  2  0 = IDLE, 1 = ACQUIRE, 2 = TRACK.
- TICK  output  1  one-cycle pulse at period boundary; TRACK only.
- JUMP  output  1  one-cycle pulse on an increment violation detected in TRACK.
- ERR_CNT  output  ERR_WIDTH  saturating count of JUMP events.
- LOCK_LOST  output  1  sticky; set when LOCKED drops while in TRACK.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset values: STATE = IDLE, TICK = 0, JUMP = 0, ERR_CNT = 0, LOCK_LOST = 0, acquire counter = 0, prev register = 0.
- Internal registers: prev (64 b, last sampled SYS_TIME) and acq_cnt (8 b).
- good = (SYS_TIME == prev + 1), computed mod 2^64. 64'hFFFF_FFFF_FFFF_FFFF → 0 is a good increment.
- Every cycle: prev <= SYS_TIME.
- IDLE:
  - LOCKED = 1 → ACQUIRE with acq_cnt = 0. The first locked sample only seeds prev.
  - Otherwise stay in IDLE.
- ACQUIRE:
  - LOCKED = 0 → IDLE.
  - good → acq_cnt++. When acq_cnt reaches ACQ_COUNT on this cycle → TRACK, acq_cnt = 0.
  - Not good → acq_cnt = 0, stay in ACQUIRE. No JUMP pulse, no error counted.
- TRACK:
  - LOCKED = 0 → IDLE and LOCK_LOST <= 1. No JUMP for that cycle.
  - Not good, including a stall (SYS_TIME == prev) → JUMP <= 1, ERR_CNT incremented (saturates at all-ones), next state ACQUIRE with acq_cnt = 0.
  - good → stay in TRACK.
- TICK:
  - Registered: TICK <= (STATE == TRACK) && LOCKED && good && SYS_TIME[TICK_LOG2-1:0] == 0.
  - Visible one cycle after the boundary sample.
  - Never asserted on a cycle that produces a JUMP.
- Output latency: JUMP and TICK are registered, one cycle after the offending or boundary SYS_TIME sample. STATE reflects the registered state.
- CLR_ERR:
  - Clears ERR_CNT and LOCK_LOST on the next edge.
  - If a JUMP and CLR_ERR occur in the same cycle, ERR_CNT = 1 (clear, then count).
  - If lock loss and CLR_ERR occur in the same cycle, LOCK_LOST = 1 (set wins).
  - CLR_ERR does not affect STATE.
- RST mid-operation: returns everything to reset values on the next edge regardless of state. Pending pulses are dropped.
- LOCKED drop in ACQUIRE or IDLE does not set LOCK_LOST.

Test Plan:
1. Reset, then LOCKED = 1 with SYS_TIME counting 1, 2, 3, … → STATE IDLE → ACQUIRE → TRACK after 1 seeding cycle + 4 good increments; ERR_CNT = 0, JUMP never high.
2. TRACK with TICK_LOG2 = 9, SYS_TIME passing 512 and 1024 → exactly one TICK per boundary, each one cycle after SYS_TIME = 512 / 1024; none in between.
3. In TRACK, force SYS_TIME 1000 → 1005 → JUMP for 1 cycle, ERR_CNT = 1, STATE = ACQUIRE, then TRACK after 4 good increments. Repeat with a stall 2000 → 2000 → ERR_CNT = 2.
4. SYS_TIME crossing 64'hFFFF_FFFF_FFFF_FFFE → …FF → 0 → 1 in TRACK → no JUMP, TICK at 0, STATE stays TRACK.
5. Drop LOCKED in TRACK → STATE = IDLE, LOCK_LOST = 1 and held; assert CLR_ERR → LOCK_LOST = 0, ERR_CNT = 0. Drop LOCKED in ACQUIRE → LOCK_LOST stays 0.
6. JUMP coincident with CLR_ERR → ERR_CNT = 1. With ERR_WIDTH = 16, 65537 injected jumps → ERR_CNT = 16'hFFFF. RST asserted in TRACK → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/sys_time_monitor.sv
// Consumer-side checker for the 64-bit system time counter: tracks +1/cycle
// advance while locked, flags jumps/stalls/lock loss and emits a period tick.
module sys_time_monitor #(
  parameter int TICK_LOG2 = 9,
  parameter int ACQ_COUNT = 4,
  parameter int ERR_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOCKED,
  input  logic [63:0]          SYS_TIME,
  input  logic                 CLR_ERR,
  output logic [1:0]           STATE,
  output logic                 TICK,
  output logic                 JUMP,
  output logic [ERR_WIDTH-1:0] ERR_CNT,
  output logic                 LOCK_LOST
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  state_t               state;
  logic [63:0]          prev;
  logic [7:0]           acq_cnt;
  logic                 good;
  logic                 boundary;
  logic [ERR_WIDTH-1:0] err_next;

  // Wraps mod 2^64, so all-ones -> 0 counts as a good increment.
  assign good     = (SYS_TIME == prev + 64'd1);
  assign boundary = (SYS_TIME[TICK_LOG2-1:0] == '0);
  // A clear in the same cycle as a jump restarts the count at one.
  assign err_next = CLR_ERR  ? ERR_WIDTH'(1) :
                    &ERR_CNT ? ERR_CNT       : ERR_CNT + ERR_WIDTH'(1);

  assign STATE = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      prev      <= '0;
      acq_cnt   <= '0;
      TICK      <= 1'b0;
      JUMP      <= 1'b0;
      ERR_CNT   <= '0;
      LOCK_LOST <= 1'b0;
    end else begin
      prev <= SYS_TIME;
      TICK <= 1'b0;
      JUMP <= 1'b0;
      if (CLR_ERR) begin
        ERR_CNT   <= '0;
        LOCK_LOST <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          // First locked sample only seeds prev.
          if (LOCKED) begin
            state   <= ACQUIRE;
            acq_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (!LOCKED) begin
            state   <= IDLE;
            acq_cnt <= '0;
          end else if (good) begin
            if (acq_cnt + 8'd1 == 8'(ACQ_COUNT)) begin
              state   <= TRACK;
              acq_cnt <= '0;
            end else begin
              acq_cnt <= acq_cnt + 8'd1;
            end
          end else begin
            acq_cnt <= '0;
          end
        end
        TRACK: begin
          if (!LOCKED) begin
            state     <= IDLE;
            LOCK_LOST <= 1'b1;
          end else if (!good) begin
            state   <= ACQUIRE;
            acq_cnt <= '0;
            JUMP    <= 1'b1;
            ERR_CNT <= err_next;
          end else begin
            TICK <= boundary;
          end
        end
        default: begin
          state   <= IDLE;
          acq_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_time_monitor.sv
// Randomized + directed bench for sys_time_monitor: two instances (default and
// narrow/fast-acquire) checked every cycle against a rule-level reference model.
module tb_sys_time_monitor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        LOCKED;
  logic [63:0] SYS_TIME;
  logic        CLR_ERR;

  logic [1:0]  state_a, state_b;
  logic        tick_a, tick_b, jump_a, jump_b, lost_a, lost_b;
  logic [15:0] err_a;
  logic [3:0]  err_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sys_time_monitor #(.TICK_LOG2(9), .ACQ_COUNT(4), .ERR_WIDTH(16)) u_dut_a (
    .CLK(CLK), .RST(RST), .LOCKED(LOCKED), .SYS_TIME(SYS_TIME), .CLR_ERR(CLR_ERR),
    .STATE(state_a), .TICK(tick_a), .JUMP(jump_a), .ERR_CNT(err_a), .LOCK_LOST(lost_a)
  );

  // Narrow counter + single-increment acquire so saturation is reachable quickly.
  sys_time_monitor #(.TICK_LOG2(2), .ACQ_COUNT(1), .ERR_WIDTH(4)) u_dut_b (
    .CLK(CLK), .RST(RST), .LOCKED(LOCKED), .SYS_TIME(SYS_TIME), .CLR_ERR(CLR_ERR),
    .STATE(state_b), .TICK(tick_b), .JUMP(jump_b), .ERR_CNT(err_b), .LOCK_LOST(lost_b)
  );

  typedef struct {
    int          st;    // 0 idle, 1 acquire, 2 track
    int          run;   // consecutive good increments while acquiring
    logic [63:0] prev;
    bit          tick;
    bit          jump;
    int          err;
    bit          lost;
  } m_t;

  m_t          ma, mb;
  logic [63:0] tm;
  int          jump_hits;
  int          tick_hits;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic m_t mstep(input m_t m, input bit rst, input bit lk,
                               input logic [63:0] t, input bit clr,
                               input int need, input int ew, input int tl);
    m_t          n;
    bit          ok;
    int          top;
    logic [63:0] mask;
    n      = m;
    n.tick = 0;
    n.jump = 0;
    n.prev = t;
    if (rst) begin
      n = '{0, 0, 64'd0, 0, 0, 0, 0};
      return n;
    end
    ok   = (t == m.prev + 64'd1);
    top  = (1 << ew) - 1;
    mask = (64'd1 << tl) - 64'd1;
    if (clr) begin
      n.err  = 0;
      n.lost = 0;
    end
    if (m.st == 0) begin
      if (lk) begin n.st = 1; n.run = 0; end
    end else if (m.st == 1) begin
      if (!lk) begin n.st = 0; n.run = 0; end
      else if (!ok) n.run = 0;
      else if (m.run + 1 == need) begin n.st = 2; n.run = 0; end
      else n.run = m.run + 1;
    end else begin
      if (!lk) begin n.st = 0; n.lost = 1; end
      else if (!ok) begin
        n.jump = 1;
        n.err  = (n.err + 1 > top) ? top : n.err + 1;
        n.st   = 1;
        n.run  = 0;
      end else n.tick = ((t & mask) == 64'd0);
    end
    return n;
  endfunction

  task automatic step(input bit rst, input bit lk, input logic [63:0] t, input bit clr);
    RST      = rst;
    LOCKED   = lk;
    SYS_TIME = t;
    CLR_ERR  = clr;
    tm       = t;
    @(posedge CLK);
    ma = mstep(ma, rst, lk, t, clr, 4, 16, 9);
    mb = mstep(mb, rst, lk, t, clr, 1, 4, 2);
    #1;
    if (jump_a) jump_hits++;
    if (tick_a) tick_hits++;
    chk("a_state", 64'(state_a), 64'(ma.st));
    chk("a_tick",  64'(tick_a),  64'(ma.tick));
    chk("a_jump",  64'(jump_a),  64'(ma.jump));
    chk("a_err",   64'(err_a),   64'(ma.err));
    chk("a_lost",  64'(lost_a),  64'(ma.lost));
    chk("b_state", 64'(state_b), 64'(mb.st));
    chk("b_tick",  64'(tick_b),  64'(mb.tick));
    chk("b_jump",  64'(jump_b),  64'(mb.jump));
    chk("b_err",   64'(err_b),   64'(mb.err));
    chk("b_lost",  64'(lost_b),  64'(mb.lost));
  endtask

  task automatic good_n(input int n);
    for (int i = 0; i < n; i++) step(0, 1, tm + 64'd1, 0);
  endtask

  initial begin
    ma = '{0, 0, 64'd0, 0, 0, 0, 0};
    mb = ma;
    tm = 64'd0;
    jump_hits = 0;
    tick_hits = 0;

    // Reset state
    step(1, 0, 64'd0, 0);
    step(1, 0, 64'd0, 0);
    chk("rst_state", 64'(state_a), 64'd0);
    chk("rst_err",   64'(err_a),   64'd0);

    // Acquire: one seeding sample then four good increments
    good_n(4);
    chk("acq_not_yet", 64'(state_a), 64'd1);
    good_n(1);
    chk("acq_track", 64'(state_a), 64'd2);
    chk("acq_no_jump", 64'(jump_hits), 64'd0);

    // Ticks at 512 and 1024 only
    tick_hits = 0;
    while (tm < 64'd1030) begin
      step(0, 1, tm + 64'd1, 0);
      if (tm == 64'd512 || tm == 64'd1024) chk("tick_bound", 64'(tick_a), 64'd1);
    end
    chk("tick_count", 64'(tick_hits), 64'd2);

    // Skip ahead, then a stall
    step(0, 1, tm + 64'd5, 0);
    chk("skip_jump", 64'(jump_a), 64'd1);
    chk("skip_err", 64'(err_a), 64'd1);
    chk("skip_state", 64'(state_a), 64'd1);
    good_n(4);
    chk("skip_retrack", 64'(state_a), 64'd2);
    step(0, 1, tm, 0);
    chk("stall_jump", 64'(jump_a), 64'd1);
    chk("stall_err", 64'(err_a), 64'd2);

    // 64-bit wrap in TRACK
    good_n(4);
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 0);
    good_n(4);
    chk("wrap_pre_track", 64'(state_a), 64'd2);
    jump_hits = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, tm + 64'd1, 0);
      if (tm == 64'd0) chk("wrap_tick", 64'(tick_a), 64'd1);
    end
    chk("wrap_no_jump", 64'(jump_hits), 64'd0);
    chk("wrap_state", 64'(state_a), 64'd2);
    chk("wrap_err", 64'(err_a), 64'd3);

    // Lock loss in TRACK is sticky until cleared
    step(0, 0, tm + 64'd1, 0);
    chk("ll_state", 64'(state_a), 64'd0);
    chk("ll_set", 64'(lost_a), 64'd1);
    step(0, 0, tm + 64'd1, 0);
    step(0, 0, tm + 64'd1, 0);
    chk("ll_hold", 64'(lost_a), 64'd1);
    step(0, 0, tm + 64'd1, 1);
    chk("ll_clr", 64'(lost_a), 64'd0);
    chk("ll_clr_err", 64'(err_a), 64'd0);
    // Lock loss during ACQUIRE is not sticky
    good_n(3);
    step(0, 0, tm + 64'd1, 0);
    chk("acq_drop_state", 64'(state_a), 64'd0);
    chk("acq_drop_lost", 64'(lost_a), 64'd0);

    // Jump with simultaneous clear, and lock loss with simultaneous clear
    good_n(5);
    step(0, 1, tm + 64'd3, 0);
    good_n(4);
    chk("jc_pre_err", 64'(err_a), 64'd1);
    step(0, 1, tm + 64'd7, 1);
    chk("jc_err", 64'(err_a), 64'd1);
    good_n(4);
    step(0, 0, tm + 64'd1, 1);
    chk("lc_lost", 64'(lost_a), 64'd1);

    // Saturation on the narrow instance
    good_n(2);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, tm + 64'd9, 0);
      step(0, 1, tm + 64'd1, 0);
    end
    chk("sat_b", 64'(err_b), 64'hF);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 78)      step(0, 1, tm + 64'd1, 0);
      else if (r < 86) step(0, 1, tm + 64'($urandom_range(2, 600)), 0);
      else if (r < 90) step(0, 1, tm, 0);
      else if (r < 94) step(0, 0, tm + 64'd1, 0);
      else if (r < 98) step(0, 1, tm + 64'd1, 1);
      else if (r < 99) step(0, 1, {$urandom, $urandom}, 0);
      else             step(1, 1, tm + 64'd1, 0);
    end

    // Reset in TRACK drops everything
    good_n(6);
    chk("prerst_track", 64'(state_a), 64'd2);
    step(1, 1, tm + 64'd5, 0);
    chk("rst_mid_state", 64'(state_a), 64'd0);
    chk("rst_mid_jump", 64'(jump_a), 64'd0);
    chk("rst_mid_tick", 64'(tick_a), 64'd0);
    chk("rst_mid_err", 64'(err_a), 64'd0);
    chk("rst_mid_lost", 64'(lost_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
